store_commit_buffer: RTL
========================

# store_commit_buffer

Holds completed store operations between the memory reservation station and the data cache. It accepts each store's resolved address and data, tagged with its ROB tag, and keeps it speculative until the ROB retires that tag. It then issues retired stores in program order on the ROB-to-memory write interface. Uncommitted entries are discarded on a branch flush.

## Interface
- DEPTH, 8: entry count; power of two, equals ROB depth
- TAG_W, 3: ROB tag width, log2(DEPTH)
- ADDR_W, 32: byte address width
- DATA_W, 32: store data width

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- st_valid  in  1  store with resolved address and data presented
- st_tag  in  TAG_W  ROB tag of the store
- st_addr  in  ADDR_W  effective address
- st_data  in  DATA_W  store data
- st_ready  out  1  buffer not full (combinational)
- commit_valid  in  1  ROB head is retiring a store this cycle
- commit_tag  in  TAG_W  tag being retired
- flush  in  1  branch mispredict flush
- mem_wr_en  out  1  write request to data cache (registered)
- mem_wr_addr  out  ADDR_W  write address (registered)
- mem_wr_data  out  DATA_W  write data (registered)
- mem_stall  in  1  data cache cannot accept this cycle
- ld_addr  in  ADDR_W  load address for forwarding lookup
- fwd_hit  out  1  youngest matching store found (combinational)
- fwd_data  out  DATA_W  data of that store
- count  out  TAG_W+1  occupied entries
- commit_err  out  1  one-cycle pulse: commit tag mismatch or nothing to commit
- overflow_err  out  1  one-cycle pulse: st_valid while full

## Operation
- Storage is a circular queue of {tag, addr, data, committed}.
- Pointers rd_ptr, cm_ptr and wr_ptr are each TAG_W+1 bits; the extra bit disambiguates wrap.
- Occupancy rules:
  - empty = (wr_ptr == rd_ptr)
  - full = low bits equal and MSBs differ
  - count = wr_ptr − rd_ptr
- Enqueue: on st_valid && !full, write to wr_ptr and increment it. On st_valid && full, the store is dropped and overflow_err pulses.
- Commit: on commit_valid, entry cm_ptr is examined.
  - If cm_ptr != wr_ptr and that entry's tag == commit_tag: set its committed bit and increment cm_ptr.
  - Otherwise: no state change, and commit_err pulses.
- Issue: the output register is "free" when mem_wr_en = 0, or when mem_wr_en = 1 and mem_stall = 0 (the write is accepted).
  - When free and the head entry is committed (rd_ptr != cm_ptr, using the registered state): load addr/data into the output register, set mem_wr_en = 1, increment rd_ptr.
  - When free and there is no committed head: mem_wr_en <= 0.
  - When not free: hold all output registers.
- Flush: set wr_ptr <= cm_ptr, discarding all uncommitted entries. Committed entries and the output register are unaffected.
- Simultaneous events in one cycle:
  - Commit is applied before flush. The entry committed that cycle survives, and wr_ptr takes the post-commit cm_ptr.
  - st_valid is ignored under flush; no overflow_err.
  - Enqueue into an empty buffer plus commit of the same tag: commit_err. The new entry is not visible to commit until the next cycle.
  - Enqueue and issue pop: both allowed. Full is evaluated before the pop.
- Forwarding: among valid entries in [rd_ptr, wr_ptr) and the output register when mem_wr_en = 1, select the youngest with addr == ld_addr. The output register counts as oldest. Report fwd_hit = 1 with that entry's data.

## Timing
- Reset values:
  - all pointers 0, all entries cleared
  - mem_wr_en, mem_wr_addr, mem_wr_data = 0
  - commit_err, overflow_err = 0
  - st_ready = 1, count = 0, fwd_hit = 0, fwd_data = 0
- A reset asserted mid-operation discards everything, including a pending stalled write.
- Latency: a store enqueued at cycle N is committable at N+1.
  - If commit occurs at cycle M with an idle output, mem_wr_en is high at M+1 … correction: the committed bit registers at M, the issue decision occurs at M+1, and mem_wr_en is high at M+2.
- Throughput: one write per cycle with back-to-back commits and mem_stall = 0.
- While mem_stall = 1, mem_wr_en/addr/data hold stable until accepted.
- commit_err and overflow_err are registered and asserted the cycle after the offending input.
- count, st_ready and fwd_* are combinational from current state.

## Configuration
- STORE_FWD_EN:
  - Defined: forwarding logic as described.
  - Undefined: fwd_hit and fwd_data are tied to 0 and ld_addr is ignored. Ports remain present.

## Test plan
- Single store: enqueue tag 2, addr 0x100, data 0xDEAD at cycle 0; commit tag 2 at cycle 2 -> mem_wr_en = 1 at cycle 4 with 0x100/0xDEAD for exactly one cycle; count returns to 0.
- Fill 8 entries, then st_valid -> st_ready = 0, overflow_err pulses, count = 8. Commit all, drain, and refill across the pointer wrap -> order preserved.
- Enqueue tags 1, 2, 3; commit 1; flush -> count = 1 and only the write for tag 1 appears. commit_tag = 5 with no pending entry -> commit_err pulse.
- Hold mem_stall = 1 for 3 cycles during a pending write -> outputs stable. The next committed store issues only after acceptance.
- With STORE_FWD_EN: stores to 0x40 with data 0x11 then 0x22, ld_addr = 0x40 -> fwd_hit = 1, fwd_data = 0x22. ld_addr = 0x44 -> fwd_hit = 0.
- Flush and commit of the head in the same cycle -> the committed entry is retained and written out.

Source files
------------

// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds resolved stores until the ROB retires them, then writes them
// to the data cache in program order. Store-to-load forwarding is built when STORE_FWD_EN is defined.
module store_commit_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [TAG_W-1:0]  st_tag,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              commit_valid,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic              flush,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_stall,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [TAG_W:0]    count,
  output logic              commit_err,
  output logic              overflow_err
);
  localparam int PW = TAG_W + 1;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  cmt_reg;

  logic [PW-1:0]     rd_ptr_reg, cm_ptr_reg, wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_next, cm_ptr_next, wr_ptr_next;
  logic [TAG_W-1:0]  rd_idx, cm_idx, wr_idx;
  logic              full, commit_ok, enq, out_free, issue;

  logic              mem_wr_en_reg;
  logic [ADDR_W-1:0] mem_wr_addr_reg;
  logic [DATA_W-1:0] mem_wr_data_reg;
  logic              commit_err_reg, overflow_err_reg;

  assign rd_idx = rd_ptr_reg[TAG_W-1:0];
  assign cm_idx = cm_ptr_reg[TAG_W-1:0];
  assign wr_idx = wr_ptr_reg[TAG_W-1:0];

  assign full     = (wr_idx == rd_idx) && (wr_ptr_reg[TAG_W] != rd_ptr_reg[TAG_W]);
  assign count    = wr_ptr_reg - rd_ptr_reg;
  assign st_ready = !full;

  // Commit only sees entries already in the queue; a same-cycle enqueue is not yet visible.
  assign commit_ok = commit_valid && (cm_ptr_reg != wr_ptr_reg) && (tag_mem[cm_idx] == commit_tag);
  assign enq       = st_valid && !full && !flush;
  assign out_free  = !mem_wr_en_reg || !mem_stall;
  assign issue     = out_free && (rd_ptr_reg != cm_ptr_reg) && cmt_reg[rd_idx];

  assign cm_ptr_next = cm_ptr_reg + PW'(commit_ok);
  assign wr_ptr_next = flush ? cm_ptr_next : wr_ptr_reg + PW'(enq);
  assign rd_ptr_next = rd_ptr_reg + PW'(issue);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem[i]  <= '0;
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
      cmt_reg <= '0;
    end else begin
      if (enq) begin
        tag_mem[wr_idx]  <= st_tag;
        addr_mem[wr_idx] <= st_addr;
        data_mem[wr_idx] <= st_data;
        cmt_reg[wr_idx]  <= 1'b0;
      end
      // commit_ok implies cm_idx differs from any slot being enqueued this cycle
      if (commit_ok) begin
        cmt_reg[cm_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg       <= '0;
      cm_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      mem_wr_en_reg    <= 1'b0;
      mem_wr_addr_reg  <= '0;
      mem_wr_data_reg  <= '0;
      commit_err_reg   <= 1'b0;
      overflow_err_reg <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      cm_ptr_reg <= cm_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      if (out_free) begin
        mem_wr_en_reg <= issue;
        if (issue) begin
          mem_wr_addr_reg <= addr_mem[rd_idx];
          mem_wr_data_reg <= data_mem[rd_idx];
        end
      end
      commit_err_reg   <= commit_valid && !commit_ok;
      overflow_err_reg <= st_valid && full && !flush;
    end
  end

  assign mem_wr_en    = mem_wr_en_reg;
  assign mem_wr_addr  = mem_wr_addr_reg;
  assign mem_wr_data  = mem_wr_data_reg;
  assign commit_err   = commit_err_reg;
  assign overflow_err = overflow_err_reg;

`ifdef STORE_FWD_EN
  logic [DEPTH-1:0] slot_hit;
  logic [TAG_W-1:0] slot_idx [DEPTH];

  // Slot gi is the gi-th oldest live entry counted from the read pointer.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_idx[gi] = rd_idx + TAG_W'(gi);
      assign slot_hit[gi] = (PW'(gi) < count) && (addr_mem[slot_idx[gi]] == ld_addr);
    end
  endgenerate

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (mem_wr_en_reg && (mem_wr_addr_reg == ld_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = mem_wr_data_reg;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_hit[k]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[slot_idx[k]];
      end
    end
  end
`else
  logic ld_addr_unused;
  assign ld_addr_unused = ^ld_addr;
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule
